// File: rtl/vending_pkg.sv
// Shared constants and FSM encoding for the vending machine owner/customer paths.
package vending_pkg;

    localparam logic [1:0] MODE_CUSTOMER  = 2'b00;
    localparam logic [1:0] MODE_CHARGE    = 2'b10;

    localparam logic [1:0] RESP_OK        = 2'b00;
    localparam logic [1:0] RESP_OVERFLOW  = 2'b01;
    localparam logic [1:0] RESP_SATURATED = 2'b10;
    localparam logic [1:0] RESP_BAD_SLOT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/charge_calc.sv
// Classifies one owner charge against the slot capacity and produces the new slot value.
module charge_calc
    import vending_pkg::*;
#(
    parameter int W   = 4,
    parameter int CAP = 15
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] amount,
    input  logic         partial,
    input  logic         slot_ok,
    output logic [W-1:0] new_val,
    output logic [1:0]   code,
    output logic [W-1:0] leftover
);

    localparam logic [W:0] CAP_X = (W+1)'(CAP);

    logic [W:0] sum;
    logic [W:0] excess;

    // One extra bit on the sum so an overflow is seen instead of wrapping.
    always_comb begin
        sum      = {1'b0, cur} + {1'b0, amount};
        excess   = sum - CAP_X;
        new_val  = cur;
        code     = RESP_OK;
        leftover = '0;
        if (!slot_ok) begin
            code = RESP_BAD_SLOT;
        end else if (sum <= CAP_X) begin
            new_val = sum[W-1:0];
        end else if (partial) begin
            code     = RESP_SATURATED;
            new_val  = CAP_X[W-1:0];
            leftover = excess[W-1:0];
        end else begin
            code = RESP_OVERFLOW;
        end
    end

endmodule

// File: rtl/owner_restock.sv
// Owner charge / customer vend unit owning the per-slot supply array.
module owner_restock
    import vending_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int W     = 4,
    parameter int CAP   = 15,
    parameter int AW    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [AW-1:0]      req_slot,
    input  logic [W-1:0]       req_amount,
    input  logic               req_partial,
    output logic               resp_valid,
    output logic [1:0]         resp_code,
    output logic [W-1:0]       resp_leftover,
    output logic               redLight,
    input  logic               vend_req,
    input  logic [AW-1:0]      vend_slot,
    output logic               vend_ok,
    output logic               vend_fail,
    output logic [SLOTS*W-1:0] supply_flat,
    output logic [SLOTS-1:0]   empty_mask
);

    localparam logic [AW:0] SLOTS_X = (AW+1)'(SLOTS);

    state_t state, state_next;
    logic   accept;

    logic [AW-1:0] lat_slot;
    logic [W-1:0]  lat_amount;
    logic          lat_partial;

    logic [W-1:0] supply [SLOTS];
    logic [W-1:0] cur_val, vend_cur;
    logic         slot_ok, vend_slot_ok;

    logic [W-1:0] c_new, c_left, r_new, r_left;
    logic [1:0]   c_code, r_code;
    logic         charge_we, vend_we, collision;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = (mode == MODE_CHARGE) && !rst;
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_val  = '0;
        vend_cur = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (lat_slot == AW'(i))  cur_val  = supply[i];
            if (vend_slot == AW'(i)) vend_cur = supply[i];
        end
        slot_ok      = {1'b0, lat_slot} < SLOTS_X;
        vend_slot_ok = {1'b0, vend_slot} < SLOTS_X;
    end

    charge_calc #(.W(W), .CAP(CAP)) u_calc (
        .cur      (cur_val),
        .amount   (lat_amount),
        .partial  (lat_partial),
        .slot_ok  (slot_ok),
        .new_val  (c_new),
        .code     (c_code),
        .leftover (c_left)
    );

    // A vend that lands on the slot of an in-flight charge would make the
    // charge result stale, so such a vend is refused until the charge retires.
    always_comb begin
        collision = (state != ST_IDLE) && (vend_slot == lat_slot);
        vend_we   = vend_req && (mode == MODE_CUSTOMER) && vend_slot_ok &&
                    (vend_cur != '0) && !collision;
        charge_we = (state == ST_RESP) &&
                    ((r_code == RESP_OK) || (r_code == RESP_SATURATED));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_slot      <= '0;
            lat_amount    <= '0;
            lat_partial   <= 1'b0;
            r_new         <= '0;
            r_code        <= RESP_OK;
            r_left        <= '0;
            resp_valid    <= 1'b0;
            resp_code     <= RESP_OK;
            resp_leftover <= '0;
            redLight      <= 1'b0;
            vend_ok       <= 1'b0;
            vend_fail     <= 1'b0;
            for (int i = 0; i < SLOTS; i++) supply[i] <= '0;
        end else begin
            resp_valid <= 1'b0;
            vend_ok    <= 1'b0;
            vend_fail  <= 1'b0;
            if (accept) begin
                lat_slot    <= req_slot;
                lat_amount  <= req_amount;
                lat_partial <= req_partial;
            end
            if (state == ST_CALC) begin
                r_new  <= c_new;
                r_code <= c_code;
                r_left <= c_left;
            end
            if (state == ST_RESP) begin
                resp_valid    <= 1'b1;
                resp_code     <= r_code;
                resp_leftover <= r_left;
                if (r_code == RESP_OK)
                    redLight <= 1'b0;
                else if (r_code != RESP_BAD_SLOT)
                    redLight <= 1'b1;
            end
            if (vend_req) begin
                vend_ok   <= vend_we;
                vend_fail <= !vend_we;
            end
            for (int i = 0; i < SLOTS; i++) begin
                if (charge_we && (lat_slot == AW'(i)))
                    supply[i] <= r_new;
                else if (vend_we && (vend_slot == AW'(i)))
                    supply[i] <= supply[i] - 1'b1;
            end
        end
    end

    always_comb begin
        supply_flat = '0;
        empty_mask  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            supply_flat[i*W +: W] = supply[i];
            empty_mask[i]         = (supply[i] == '0);
        end
    end

endmodule

// File: tb/tb_owner_restock.sv
// Randomised scoreboard bench for owner_restock with a three-slot instance.
module tb_owner_restock;

    localparam int NS   = 3;
    localparam int CAPM = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_slot;
    logic [3:0]  req_amount;
    logic        req_partial;
    logic        resp_valid;
    logic [1:0]  resp_code;
    logic [3:0]  resp_leftover;
    logic        redLight;
    logic        vend_req;
    logic [1:0]  vend_slot;
    logic        vend_ok;
    logic        vend_fail;
    logic [11:0] supply_flat;
    logic [2:0]  empty_mask;

    owner_restock #(.SLOTS(NS), .W(4), .CAP(CAPM), .AW(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_slot      (req_slot),
        .req_amount    (req_amount),
        .req_partial   (req_partial),
        .resp_valid    (resp_valid),
        .resp_code     (resp_code),
        .resp_leftover (resp_leftover),
        .redLight      (redLight),
        .vend_req      (vend_req),
        .vend_slot     (vend_slot),
        .vend_ok       (vend_ok),
        .vend_fail     (vend_fail),
        .supply_flat   (supply_flat),
        .empty_mask    (empty_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] code;
        logic [3:0] left;
        bit         ok;
        logic [11:0] flat;
        logic [2:0] empty;
        bit         red;
    } exp_t;

    exp_t rq[$];
    exp_t vq[$];

    int ms [NS];
    bit mred;
    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] flatOf();
        logic [11:0] f = '0;
        for (int i = 0; i < NS; i++) f[i*4 +: 4] = ms[i][3:0];
        return f;
    endfunction

    function automatic logic [2:0] emptyOf();
        logic [2:0] e = '0;
        for (int i = 0; i < NS; i++) e[i] = (ms[i] == 0);
        return e;
    endfunction

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            checkOutput("resp_valid_in_reset", {31'b0, resp_valid}, 0);
        end else begin
            if (resp_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    checkOutput("resp_unexpected", 1, 0);
                end else begin
                    e = rq.pop_front();
                    checkOutput("resp_latency", cyc, e.cyc);
                    checkOutput("resp_code", {30'b0, resp_code}, {30'b0, e.code});
                    checkOutput("resp_leftover", {28'b0, resp_leftover}, {28'b0, e.left});
                    checkOutput("resp_redLight", {31'b0, redLight}, {31'b0, e.red});
                    checkOutput("resp_supply", {20'b0, supply_flat}, {20'b0, e.flat});
                    checkOutput("resp_empty", {29'b0, empty_mask}, {29'b0, e.empty});
                end
            end
            if ((vend_ok === 1'b1) || (vend_fail === 1'b1)) begin
                if (vq.size() == 0) begin
                    checkOutput("vend_unexpected", 1, 0);
                end else begin
                    e = vq.pop_front();
                    checkOutput("vend_latency", cyc, e.cyc);
                    checkOutput("vend_ok", {31'b0, vend_ok}, {31'b0, e.ok});
                    checkOutput("vend_fail", {31'b0, vend_fail}, {31'b0, !e.ok});
                    checkOutput("vend_supply", {20'b0, supply_flat}, {20'b0, e.flat});
                    checkOutput("vend_empty", {29'b0, empty_mask}, {29'b0, e.empty});
                    checkOutput("vend_redLight", {31'b0, redLight}, {31'b0, e.red});
                end
            end
        end
    end

    // Issues one charge (is_vend=0) or one vend (is_vend=1) and queues its expected outcome.
    task automatic applyStimulus(input bit is_vend, input int slot, input int amount,
                                 input bit partial, input logic [1:0] m, input bit flip);
        exp_t e;
        int   sum;
        @(negedge clk);
        mode = m;
        e.left = '0;
        e.code = 2'b00;
        e.ok   = 1'b0;
        if (is_vend) begin
            vend_req  = 1'b1;
            vend_slot = slot[1:0];
            e.cyc = cyc + 1;
            if (m == 2'b00 && slot < NS && ms[slot] > 0) begin
                ms[slot]--;
                e.ok = 1'b1;
            end
        end else begin
            req_valid   = 1'b1;
            req_slot    = slot[1:0];
            req_amount  = amount[3:0];
            req_partial = partial;
            e.cyc = cyc + 3;
            if (slot >= NS) begin
                e.code = 2'b11;
            end else begin
                sum = ms[slot] + amount;
                if (sum <= CAPM) begin
                    e.code = 2'b00; ms[slot] = sum; mred = 1'b0;
                end else if (partial) begin
                    e.code = 2'b10; e.left = 4'(sum - CAPM); ms[slot] = CAPM; mred = 1'b1;
                end else begin
                    e.code = 2'b01; mred = 1'b1;
                end
            end
        end
        e.flat  = flatOf();
        e.empty = emptyOf();
        e.red   = mred;
        if (is_vend) vq.push_back(e);
        else         rq.push_back(e);
        if (!is_vend) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (flip) mode = 2'b00;
        end
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            vend_req  = 1'b0;
            req_valid = 1'b0;
            if (rq.size() == 0 && vq.size() == 0) break;
        end
        checkOutput("drain_timeout", rq.size() + vq.size(), 0);
        rq.delete();
        vq.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1; mode = 2'b10; req_valid = 1'b1; req_slot = 2'd0;
        req_amount = 4'd5; req_partial = 1'b0; vend_req = 1'b0; vend_slot = 2'd0;
        for (int i = 0; i < NS; i++) ms[i] = 0;
        mred = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        checkOutput("reset_supply", {20'b0, supply_flat}, 0);
        checkOutput("reset_empty", {29'b0, empty_mask}, 32'h7);
        checkOutput("reset_redLight", {31'b0, redLight}, 0);
        checkOutput("reset_vend", {30'b0, vend_ok, vend_fail}, 0);
        checkOutput("reset_resp", {26'b0, resp_code, resp_leftover}, 0);
        mode = 2'b00; #1;
        checkOutput("ready_customer", {31'b0, req_ready}, 0);
        mode = 2'b10; #1;
        checkOutput("ready_charge", {31'b0, req_ready}, 1);

        applyStimulus(0, 2, 9, 0, 2'b10, 0);  waitDrain();
        applyStimulus(0, 2, 6, 0, 2'b10, 0);  waitDrain();
        applyStimulus(0, 2, 1, 0, 2'b10, 0);  waitDrain();
        applyStimulus(0, 0, 0, 0, 2'b10, 0);  waitDrain();
        applyStimulus(0, 1, 2, 0, 2'b10, 0);  waitDrain();
        applyStimulus(1, 1, 0, 0, 2'b00, 0);
        applyStimulus(1, 1, 0, 0, 2'b00, 0);
        applyStimulus(1, 1, 0, 0, 2'b00, 0);  waitDrain();
        applyStimulus(1, 2, 0, 0, 2'b10, 0);  waitDrain();
        applyStimulus(0, 1, 12, 0, 2'b10, 0); waitDrain();
        applyStimulus(0, 1, 7, 1, 2'b10, 0);  waitDrain();
        applyStimulus(0, 3, 5, 0, 2'b10, 0);  waitDrain();
        applyStimulus(0, 0, 3, 0, 2'b10, 1);  waitDrain();

        // Reset while a charge sits in CALC must drop it silently.
        @(negedge clk);
        mode = 2'b10; req_valid = 1'b1; req_slot = 2'd0; req_amount = 4'd4; req_partial = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NS; i++) ms[i] = 0;
        mred = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_supply", {20'b0, supply_flat}, 0);

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) < 5) begin
                applyStimulus(0, $urandom_range(0, 3), $urandom_range(0, 15),
                              1'($urandom_range(0, 1)), 2'b10, ($urandom_range(0, 3) == 0));
            end else begin
                n = $urandom_range(1, 3);
                for (int v = 0; v < n; v++)
                    applyStimulus(1, $urandom_range(0, 3), 0, 0,
                                  ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00, 0);
            end
            waitDrain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
